// File: rtl/rv_core_pkg.sv
// Shared core definitions: data widths, NOP encoding and fetch FSM states.
package rv_core_pkg;

  localparam int XLEN  = 32;
  localparam int OPC_W = 7;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_FULL = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_gen.sv
// Next fetch address: redirect target, sequential +4 (mod 2^32) or hold.
module pc_next_gen
  import rv_core_pkg::*;
(
  input  logic [XLEN-1:0] i_cur_addr,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic            i_advance,
  output logic [XLEN-1:0] o_next_addr
);

  // Redirect has priority over sequential advance.
  always_comb begin
    if (i_branch_taken) begin
      o_next_addr = word_align(i_branch_target);
    end else if (i_advance) begin
      o_next_addr = i_cur_addr + 32'd4;
    end else begin
      o_next_addr = i_cur_addr;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Single-entry instruction fetch buffer with branch redirect and
// discard of in-flight reads that a redirect has made stale.
module inst_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] INST,
  output logic [6:0]  OPE_CODE,
  output logic [31:0] PC,
  output logic        INST_VALID,
  input  logic        INST_READY
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic            r_started;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_pend;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_cur_addr;
  logic [XLEN-1:0] w_next_addr;
  logic [XLEN-1:0] w_addr_nxt;
  logic            w_accept;
  logic            w_stall_redirect;

  // In S_DROP the bus keeps the stale address; redirects accumulate in r_pend.
  assign w_cur_addr       = (r_state == S_DROP) ? r_pend : r_addr;
  assign w_accept         = (r_state == S_REQ) && IMEM_REQ && IMEM_ACK && !BRANCH_TAKEN;
  assign w_stall_redirect = (r_state == S_REQ) && r_started && BRANCH_TAKEN && !IMEM_ACK;

  pc_next_gen u_pc_next_gen (
    .i_cur_addr      (w_cur_addr),
    .i_branch_taken  (BRANCH_TAKEN),
    .i_branch_target (BRANCH_TARGET),
    .i_advance       (w_accept),
    .o_next_addr     (w_next_addr)
  );

  // State register; r_started keeps the request low until the first edge after reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_REQ;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        if (w_stall_redirect) begin
          w_state_nxt = S_DROP;
        end else if (w_accept) begin
          w_state_nxt = S_FULL;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_FULL: begin
        if (BRANCH_TAKEN || INST_READY) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_FULL;
        end
      end
      S_DROP: begin
        if (IMEM_ACK) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_DROP;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    IMEM_REQ   = 1'b0;
    INST_VALID = 1'b0;
    case (r_state)
      S_REQ:   IMEM_REQ   = r_started;
      S_DROP:  IMEM_REQ   = r_started;
      S_FULL:  INST_VALID = 1'b1;
      default: IMEM_REQ   = 1'b0;
    endcase
  end

  // Bus address update: held while a read is outstanding and unacknowledged.
  always_comb begin
    w_addr_nxt = r_addr;
    case (r_state)
      S_REQ: begin
        if (w_stall_redirect) begin
          w_addr_nxt = r_addr;
        end else begin
          w_addr_nxt = w_next_addr;
        end
      end
      S_FULL: w_addr_nxt = w_next_addr;
      S_DROP: begin
        if (IMEM_ACK) begin
          w_addr_nxt = w_next_addr;
        end else begin
          w_addr_nxt = r_addr;
        end
      end
      default: w_addr_nxt = r_addr;
    endcase
  end

  // Fetch datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_addr <= RESET_PC;
      r_pend <= RESET_PC;
      r_inst <= NOP_INST;
      r_pc   <= RESET_PC;
    end else begin
      r_addr <= w_addr_nxt;
      if (BRANCH_TAKEN) begin
        r_pend <= w_next_addr;
      end
      if (w_accept) begin
        r_inst <= IMEM_RDATA;
        r_pc   <= r_addr;
      end
    end
  end

  assign IMEM_ADDR = r_addr;
  assign INST      = r_inst;
  assign PC        = r_pc;
  assign OPE_CODE  = r_inst[OPC_W-1:0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed and randomized bench for inst_fetch_unit against an in-order
// delivered-PC model and an address-tagged instruction memory.
module tb_inst_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, br, ack, ready;
  logic [31:0] tgt, rdata;
  logic        o_req, o_valid;
  logic [31:0] o_addr, o_inst, o_pc;
  logic [6:0]  o_opc;

  logic        req2, valid2, ack2;
  logic [31:0] addr2, inst2, pc2, rdata2;
  logic [6:0]  opc2;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  assign ack2   = req2;
  assign rdata2 = mem_word(addr2);

  inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(clk), .RST_N(rst_n), .BRANCH_TAKEN(br), .BRANCH_TARGET(tgt),
    .IMEM_REQ(o_req), .IMEM_ADDR(o_addr), .IMEM_ACK(ack), .IMEM_RDATA(rdata),
    .INST(o_inst), .OPE_CODE(o_opc), .PC(o_pc), .INST_VALID(o_valid),
    .INST_READY(ready)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .CLK(clk), .RST_N(rst_n), .BRANCH_TAKEN(1'b0), .BRANCH_TARGET(32'h0000_0000),
    .IMEM_REQ(req2), .IMEM_ADDR(addr2), .IMEM_ACK(ack2), .IMEM_RDATA(rdata2),
    .INST(inst2), .OPE_CODE(opc2), .PC(pc2), .INST_VALID(valid2),
    .INST_READY(1'b1)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;
  int          delivered;
  int          wait_cnt;
  int          lat;
  bit          lat_rand;
  logic        prev_hold, prev_br, prev_keep;
  logic [31:0] prev_addr, prev_inst, prev_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: memory responds, inputs applied, model updated, outputs checked.
  task automatic cycle(input logic b, input logic [31:0] t, input logic rdy);
    logic [31:0] w;
    if (o_req && wait_cnt >= lat) begin
      ack = 1'b1; rdata = mem_word(o_addr);
    end else begin
      ack = 1'b0; rdata = $urandom;
    end
    br = b; tgt = t; ready = rdy;
    if (o_valid && rdy) begin
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    if (b) exp_pc = {t[31:2], 2'b00};
    prev_hold = o_req && !ack;
    prev_addr = o_addr;
    prev_br   = b;
    prev_keep = o_valid && !rdy && !b;
    prev_inst = o_inst;
    prev_pc   = o_pc;
    @(posedge clk);
    @(negedge clk);
    if (ack) begin
      wait_cnt = 0;
      if (lat_rand) lat = int'($urandom_range(0, 3));
    end else if (prev_hold) begin
      wait_cnt++;
    end
    if (prev_hold) begin
      chk("req_held", {31'd0, o_req}, 32'd1);
      chk("addr_held", o_addr, prev_addr);
    end
    if (prev_br) chk("valid_after_branch", {31'd0, o_valid}, 32'd0);
    if (prev_keep) begin
      chk("hold_valid", {31'd0, o_valid}, 32'd1);
      chk("hold_inst", o_inst, prev_inst);
      chk("hold_pc", o_pc, prev_pc);
    end
    if (o_valid) begin
      w = mem_word(exp_pc);
      chk("pc", o_pc, exp_pc);
      chk("inst", o_inst, w);
      chk("opcode", {25'd0, o_opc}, {25'd0, w[6:0]});
    end
  endtask

  // Reset entered at a negedge; checks asynchronous effect and reset values.
  task automatic do_reset();
    rst_n = 1'b0; br = 1'b0; ack = 1'b0; ready = 1'b0; tgt = 32'd0;
    #1;
    chk("rst_req_async", {31'd0, o_req}, 32'd0);
    chk("rst_valid_async", {31'd0, o_valid}, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, o_req}, 32'd0);
    chk("rst_pc", o_pc, 32'h0000_0000);
    chk("rst_inst", o_inst, 32'h0000_0013);
    chk("rst_opcode", {25'd0, o_opc}, 32'h0000_0013);
    chk("rst_addr", o_addr, 32'h0000_0000);
    rst_n = 1'b1;
    #1;
    chk("req_low_at_release", {31'd0, o_req}, 32'd0);
    exp_pc = 32'h0000_0000; wait_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] w;
    rst_n = 1'b0; br = 1'b0; ack = 1'b0; ready = 1'b0; tgt = 32'd0; rdata = 32'd0;
    delivered = 0; lat = 0; lat_rand = 1'b0;
    @(negedge clk);
    do_reset();

    // Zero-wait memory, always ready: one instruction every two cycles.
    for (int i = 0; i < 8; i++) begin
      chk("tput_valid", {31'd0, o_valid}, (i >= 2 && i % 2 == 0) ? 32'd1 : 32'd0);
      if (i == 1) begin
        chk("wrap_req0", {31'd0, req2}, 32'd1);
        chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
      end
      if (i == 2) begin
        w = mem_word(32'hFFFF_FFFC);
        chk("wrap_pc0", pc2, 32'hFFFF_FFFC);
        chk("wrap_inst0", inst2, w);
        chk("wrap_opc0", {25'd0, opc2}, {25'd0, w[6:0]});
      end
      if (i == 3) chk("wrap_addr1", addr2, 32'h0000_0000);
      if (i == 4) chk("wrap_pc1", pc2, 32'h0000_0000);
      cycle(1'b0, 32'd0, 1'b1);
    end
    chk("tput_next_pc", exp_pc, 32'h0000_000C);

    // Three-cycle memory latency and a stalled consumer.
    do_reset();
    lat = 3; n = 0;
    for (int i = 0; i < 20 && !o_valid; i++) begin
      if (o_req) n++;
      cycle(1'b0, 32'd0, 1'b0);
    end
    chk("req_cycles", 32'(n), 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("stall_no_req", {31'd0, o_req}, 32'd0);
      chk("stall_valid", {31'd0, o_valid}, 32'd1);
      cycle(1'b0, 32'd0, 1'b0);
    end
    cycle(1'b0, 32'd0, 1'b1);
    chk("resume_req", {31'd0, o_req}, 32'd1);
    chk("resume_addr", o_addr, 32'h0000_0004);

    // Redirect while the read of 0x8 is outstanding; its data must vanish.
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_req && o_addr == 32'h0000_0008) break;
      cycle(1'b0, 32'd0, 1'b1);
    end
    chk("reach_8", o_addr, 32'h0000_0008);
    lat = 2;
    cycle(1'b1, 32'h0000_0103, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    chk("drop_req", {31'd0, o_req}, 32'd1);
    chk("drop_addr", o_addr, 32'h0000_0100);
    chk("drop_valid", {31'd0, o_valid}, 32'd0);
    lat = 0;
    for (int i = 0; i < 20 && !o_valid; i++) cycle(1'b0, 32'd0, 1'b1);
    chk("target_pc", o_pc, 32'h0000_0100);

    // Redirect coincident with ACK, then with a handshake.
    cycle(1'b0, 32'd0, 1'b1);
    chk("pre_ack_req", {31'd0, o_req}, 32'd1);
    cycle(1'b1, 32'h0000_0200, 1'b1);
    chk("ackbr_req", {31'd0, o_req}, 32'd1);
    chk("ackbr_addr", o_addr, 32'h0000_0200);
    cycle(1'b0, 32'd0, 1'b1);
    chk("ackbr_valid", {31'd0, o_valid}, 32'd1);
    n = delivered;
    cycle(1'b1, 32'h0000_0302, 1'b1);
    chk("hsbr_delivered", 32'(delivered - n), 32'd1);
    chk("hsbr_addr", o_addr, 32'h0000_0300);
    chk("hsbr_req", {31'd0, o_req}, 32'd1);
    cycle(1'b0, 32'd0, 1'b1);
    chk("hsbr_pc", o_pc, 32'h0000_0300);

    // Reset in the middle of an outstanding request.
    lat = 3;
    cycle(1'b0, 32'd0, 1'b1);
    chk("mid_req", {31'd0, o_req}, 32'd1);
    do_reset();
    for (int i = 0; i < 4 && !o_req; i++) cycle(1'b0, 32'd0, 1'b1);
    chk("restart_addr", o_addr, 32'h0000_0000);

    // Random latency, readiness and redirects.
    lat_rand = 1'b1;
    lat = int'($urandom_range(0, 3));
    n = delivered;
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 3) != 0));
    end
    chk("progress", {31'd0, (delivered - n) > 200}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
